// File: rtl/vga_arb_pkg.sv
// Shared constants and state encoding for the VGA pixel-port arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package vga_arb_pkg;

    localparam int VGA_W = 640;
    localparam int VGA_H = 480;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int C_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: searches last+1, last+2, ... modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [LW-1:0] grant_idx
);

    logic          found;
    int            idx_i;
    logic [LW-1:0] idx;

    // Walk the requesters starting just after the last winner; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_i     = 0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx_i = int'(last) + k;
            if (idx_i >= N) begin
                idx_i = idx_i - N;
            end
            idx = LW'(idx_i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares one VGA pixel port among N_REQ requesters; optional VGA_ARB_CLIP_EN drops off-screen pixels.
// Latency: plot pulses the cycle after acceptance; one pixel per 2+PLOT_GAP cycles at most.
// Backpressure: req_ready only in IDLE (one-hot); requesters hold valid/data until ready.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int PLOT_GAP = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  Resetn,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [X_W*N_REQ-1:0]  req_x,
    input  logic [Y_W*N_REQ-1:0]  req_y,
    input  logic [C_W*N_REQ-1:0]  req_color,
    output logic [N_REQ-1:0]      req_ready,
    output logic [X_W-1:0]        VGA_X,
    output logic [Y_W-1:0]        VGA_Y,
    output logic [C_W-1:0]        VGA_COLOR,
    output logic                  plot,
    output logic                  busy
`ifdef VGA_ARB_CLIP_EN
    ,
    output logic [15:0]           clip_count
`endif
);

    localparam int         LW       = $clog2(N_REQ);
    localparam logic [3:0] GAP_LOAD = (PLOT_GAP > 0) ? 4'(PLOT_GAP - 1) : 4'd0;

    arb_state_t     state_q, state_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic [LW-1:0]  last_q, last_d;
    logic [X_W-1:0] vga_x_q, vga_x_d;
    logic [Y_W-1:0] vga_y_q, vga_y_d;
    logic [C_W-1:0] vga_c_q, vga_c_d;
    logic [15:0]    clip_count_q, clip_count_d;

    logic [N_REQ-1:0] grant;
    logic [LW-1:0]    grant_idx;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;
    logic             accept;
    logic             off_screen;

    rr_arbiter #(
        .N  (N_REQ),
        .LW (LW)
    ) u_rr (
        .req       (req_valid),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Mux the granted requester's pixel out of the flattened buses.
    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_x = req_x[i*X_W +: X_W];
                sel_y = req_y[i*Y_W +: Y_W];
                sel_c = req_color[i*C_W +: C_W];
            end
        end
    end

`ifdef VGA_ARB_CLIP_EN
    assign off_screen = (sel_x >= X_W'(VGA_W)) || (sel_y >= Y_W'(VGA_H));
`else
    assign off_screen = 1'b0;
`endif

    assign accept = (state_q == IDLE) && (|grant);

    // Ready is gated by the reset pin so it is already low while reset is held.
    assign req_ready = (state_q == IDLE && Resetn) ? grant : '0;
    assign plot      = (state_q == PLOT);
    assign busy      = (state_q != IDLE);
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_c_q;

    // Next-state: accept in IDLE, single plot cycle, then count out the idle gap.
    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        last_d       = last_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_c_d      = vga_c_q;
        clip_count_d = clip_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_d = grant_idx;
                    if (off_screen) begin
                        // Dropped pixel: consumed but never plotted.
                        if (clip_count_q != 16'hFFFF) begin
                            clip_count_d = clip_count_q + 16'd1;
                        end
                    end else begin
                        vga_x_d = sel_x;
                        vga_y_d = sel_y;
                        vga_c_d = sel_c;
                        state_d = PLOT;
                    end
                end
            end
            PLOT: begin
                if (PLOT_GAP > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight pixel.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            gap_cnt_q    <= 4'd0;
            last_q       <= LW'(N_REQ - 1);
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_c_q      <= '0;
            clip_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            last_q       <= last_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_c_q      <= vga_c_d;
            clip_count_q <= clip_count_d;
        end
    end

`ifdef VGA_ARB_CLIP_EN
    assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter with N_REQ=4, PLOT_GAP=1.
// Inputs change just after the falling edge; outputs are checked before the next rising edge.
// Clip checks run only when VGA_ARB_CLIP_EN is defined.
module tb_vga_plot_arbiter;

    logic        CLOCK_50 = 1'b0;
    logic        Resetn;
    logic [3:0]  req_valid;
    logic [39:0] req_x;
    logic [35:0] req_y;
    logic [11:0] req_color;
    logic [3:0]  req_ready;
    logic [9:0]  VGA_X;
    logic [8:0]  VGA_Y;
    logic [2:0]  VGA_COLOR;
    logic        plot;
    logic        busy;
`ifdef VGA_ARB_CLIP_EN
    logic [15:0] clip_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int plots_per_req [4];

    vga_plot_arbiter #(
        .N_REQ    (4),
        .PLOT_GAP (1)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .Resetn    (Resetn),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .req_ready (req_ready),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy)
`ifdef VGA_ARB_CLIP_EN
        ,
        .clip_count (clip_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int i, input logic [9:0] x, input logic [8:0] y, input logic [2:0] c);
        req_x[i*10 +: 10]   = x;
        req_y[i*9 +: 9]     = y;
        req_color[i*3 +: 3] = c;
    endtask

    task automatic nxt;
        @(negedge CLOCK_50);
        #1;
    endtask

    initial begin
        Resetn    = 1'b0;
        req_valid = 4'b1111;
        req_x     = '0;
        req_y     = '0;
        req_color = '0;
        for (int i = 0; i < 4; i++) begin
            set_pix(i, 10'(100 + i), 9'(200 + i), 3'(i + 1));
            plots_per_req[i] = 0;
        end

        // Reset held with every requester valid.
        nxt;
        nxt;
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_x", VGA_X, 0);
        chk("rst_y", VGA_Y, 0);
        chk("rst_color", VGA_COLOR, 0);

        // Release: requester 0 first, then strict rotation, one plot per 3 cycles.
        Resetn = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            chk("fair_ready", req_ready, 32'(1 << (k % 4)));
            chk("fair_idle_busy", busy, 0);
            nxt;
            chk("fair_plot", plot, 1);
            chk("fair_x", VGA_X, 32'(100 + (k % 4)));
            chk("fair_y", VGA_Y, 32'(200 + (k % 4)));
            chk("fair_ready_in_plot", req_ready, 0);
            if (plot && VGA_X >= 10'd100 && VGA_X < 10'd104) begin
                plots_per_req[VGA_X - 10'd100]++;
            end
            nxt;
            chk("fair_gap_plot", plot, 0);
            chk("fair_gap_busy", busy, 1);
            nxt;
        end
        for (int i = 0; i < 4; i++) begin
            chk("fair_count", 32'(plots_per_req[i]), 3);
        end
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", req_ready, 0);
        chk("idle_busy", busy, 0);

        // Single pixel from requester 2 (last pointer is 3 here).
        set_pix(2, 10'd100, 9'd50, 3'd5);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", req_ready, 4'b0100);
        nxt;
        chk("single_plot", plot, 1);
        chk("single_x", VGA_X, 100);
        chk("single_y", VGA_Y, 50);
        chk("single_color", VGA_COLOR, 5);
        chk("single_busy", busy, 1);
        req_valid = 4'b0000;
        nxt;
        chk("single_gap_plot", plot, 0);
        chk("single_gap_busy", busy, 1);
        nxt;
        chk("single_idle_busy", busy, 0);
        chk("single_hold_x", VGA_X, 100);

        // Requester 1 waits through PLOT/GAP while its x moves; accepted in IDLE.
        set_pix(0, 10'd7, 9'd1, 3'd2);
        req_valid = 4'b0001;
        #1;
        chk("hold_ready0", req_ready, 4'b0001);
        nxt;
        req_valid = 4'b0010;
        set_pix(1, 10'd300, 9'd3, 3'd3);
        #1;
        chk("hold_ready_plot", req_ready, 0);
        chk("hold_x0", VGA_X, 7);
        nxt;
        set_pix(1, 10'd301, 9'd3, 3'd3);
        #1;
        chk("hold_ready_gap", req_ready, 0);
        nxt;
        set_pix(1, 10'd302, 9'd4, 3'd6);
        #1;
        chk("hold_ready1", req_ready, 4'b0010);
        nxt;
        chk("hold_plot", plot, 1);
        chk("hold_x_plot", VGA_X, 302);
        req_valid = 4'b0000;
        set_pix(1, 10'd999, 9'd9, 3'd1);
        #1;
        chk("hold_x_plot_late", VGA_X, 302);
        nxt;
        chk("hold_x_gap", VGA_X, 302);
        chk("hold_color_gap", VGA_COLOR, 6);
        nxt;

        // Reset asserted mid-PLOT: plot drops at once, pixel discarded.
        set_pix(3, 10'd555, 9'd100, 3'd7);
        req_valid = 4'b1000;
        #1;
        chk("mrst_ready", req_ready, 4'b1000);
        nxt;
        chk("mrst_plot_before", plot, 1);
        chk("mrst_x_before", VGA_X, 555);
        #3;
        Resetn = 1'b0;
        #1;
        chk("mrst_plot", plot, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_x", VGA_X, 0);
        chk("mrst_y", VGA_Y, 0);
        chk("mrst_color", VGA_COLOR, 0);
        chk("mrst_ready", req_ready, 0);
        req_valid = 4'b0000;
        nxt;
        nxt;
        Resetn = 1'b1;
        #1;
        nxt;
        chk("mrst_no_plot", plot, 0);
        chk("mrst_no_busy", busy, 0);
        chk("mrst_x_after", VGA_X, 0);
        req_valid = 4'b1111;
        #1;
        chk("mrst_first_grant", req_ready, 4'b0001);
        req_valid = 4'b0000;
        #1;

`ifdef VGA_ARB_CLIP_EN
        // Off-screen pixel is consumed without plotting; next one plots normally.
        set_pix(0, 10'd640, 9'd0, 3'd1);
        req_valid = 4'b0001;
        #1;
        chk("clip_ready0", req_ready, 4'b0001);
        chk("clip_count0", clip_count, 0);
        nxt;
        set_pix(1, 10'd639, 9'd479, 3'd3);
        req_valid = 4'b0010;
        #1;
        chk("clip_plot", plot, 0);
        chk("clip_busy", busy, 0);
        chk("clip_count1", clip_count, 1);
        chk("clip_x_unchanged", VGA_X, 0);
        chk("clip_ready1", req_ready, 4'b0010);
        nxt;
        req_valid = 4'b0000;
        chk("clip_edge_plot", plot, 1);
        chk("clip_edge_x", VGA_X, 639);
        chk("clip_edge_y", VGA_Y, 479);
        chk("clip_count_hold", clip_count, 1);
        nxt;
        nxt;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
